// File: rtl/riscv_core_32bit_divider.sv
// riscv_core_32bit_divider: multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Divides magnitudes one quotient bit per cycle, then applies the sign fix-up when entering DONE.
module riscv_core_32bit_divider #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_div_start,
    input  logic [1:0]      i_div_op,
    input  logic [XLEN-1:0] i_div_srcA,
    input  logic [XLEN-1:0] i_div_srcB,
    input  logic            i_div_flush,
    output logic            o_div_busy,
    output logic            o_div_valid,
    output logic [XLEN-1:0] o_div_result
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN:0]   rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic            negq_q, negq_d;
    logic            negr_q, negr_d;
    logic            isrem_q, isrem_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            sgn, a_neg, b_neg, div_zero, ovf, trial_ok;
    logic [XLEN-1:0] mag_a, mag_b, quo_nx;
    logic [XLEN+1:0] shifted, diff;
    logic [XLEN:0]   rem_nx;

    assign sgn      = ~i_div_op[0];
    assign a_neg    = sgn & i_div_srcA[XLEN-1];
    assign b_neg    = sgn & i_div_srcB[XLEN-1];
    assign mag_a    = a_neg ? -i_div_srcA : i_div_srcA;
    assign mag_b    = b_neg ? -i_div_srcB : i_div_srcB;
    assign div_zero = i_div_srcB == '0;
    assign ovf      = sgn && i_div_srcA == {1'b1, {(XLEN-1){1'b0}}} && i_div_srcB == '1;

    // Extra top bit keeps the borrow of the trial subtract visible.
    assign shifted  = {rem_q, quo_q[XLEN-1]};
    assign diff     = shifted - {2'b00, dvs_q};
    assign trial_ok = ~diff[XLEN+1];
    assign rem_nx   = trial_ok ? diff[XLEN:0] : shifted[XLEN:0];
    assign quo_nx   = {quo_q[XLEN-2:0], trial_ok};

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        isrem_d  = isrem_q;
        result_d = result_q;
        if (i_div_flush) begin
            state_d = IDLE;
        end else if (state_q == CALC) begin
            rem_d   = rem_nx;
            quo_d   = quo_nx;
            count_d = count_q + CW'(1);
            if (count_q == CW'(XLEN-1)) begin
                state_d  = DONE;
                result_d = isrem_q ? (negr_q ? -rem_nx[XLEN-1:0] : rem_nx[XLEN-1:0])
                                   : (negq_q ? -quo_nx : quo_nx);
            end
        end else if (i_div_start) begin
            if (div_zero) begin
                state_d  = DONE;
                result_d = i_div_op[1] ? i_div_srcA : '1;
            end else if (ovf) begin
                state_d  = DONE;
                result_d = i_div_op[1] ? '0 : i_div_srcA;
            end else begin
                state_d = CALC;
                count_d = '0;
                rem_d   = '0;
                quo_d   = mag_a;
                dvs_d   = mag_b;
                negq_d  = a_neg ^ b_neg;
                negr_d  = a_neg;
                isrem_d = i_div_op[1];
            end
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            isrem_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            isrem_q  <= isrem_d;
            result_q <= result_d;
        end
    end

    assign o_div_busy   = state_q == CALC;
    assign o_div_valid  = state_q == DONE;
    assign o_div_result = result_q;
endmodule

// File: tb/tb_riscv_core_32bit_divider.sv
// tb_riscv_core_32bit_divider: directed vector table plus handshake, flush and reset sequences.
module tb_riscv_core_32bit_divider;
    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, valid;
    logic [31:0] res;
    int          passed = 0;
    int          total = 0;

    localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t v[16];

    riscv_core_32bit_divider dut (
        .i_clk(clk), .i_rst(rst), .i_div_start(start), .i_div_op(op),
        .i_div_srcA(a), .i_div_srcB(b), .i_div_flush(flush),
        .o_div_busy(busy), .o_div_valid(valid), .o_div_result(res)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic go(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_valid(input int l0, output int lat);
        lat = l0;
        while (!valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat, seen;
        v[0]  = '{DIVU, 32'd100, 32'd7, 32'h0000000E, 33};
        v[1]  = '{REMU, 32'd100, 32'd7, 32'h00000002, 33};
        v[2]  = '{DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33};
        v[3]  = '{REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33};
        v[4]  = '{REM, 32'd7, 32'hFFFFFFFE, 32'h00000001, 33};
        v[5]  = '{DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 1};
        v[6]  = '{REM, 32'd5, 32'd0, 32'h00000005, 1};
        v[7]  = '{DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        v[8]  = '{REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
        v[9]  = '{DIV, 32'd0, 32'd0, 32'hFFFFFFFF, 1};
        v[10] = '{REMU, 32'd9, 32'd0, 32'h00000009, 1};
        v[11] = '{DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 33};
        v[12] = '{REMU, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33};
        v[13] = '{DIV, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h00000003, 33};
        v[14] = '{DIVU, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33};
        v[15] = '{DIV, 32'h80000000, 32'd2, 32'hC0000000, 33};

        rst = 1'b1; start = 1'b0; flush = 1'b0; op = DIVU; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_valid", {31'd0, valid}, 32'd0);
        chk("reset_result", res, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            go(v[i].op, v[i].a, v[i].b);
            wait_valid(1, lat);
            chk($sformatf("vec%0d_result", i), res, v[i].exp);
            chk($sformatf("vec%0d_latency", i), lat, v[i].lat);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_valid_one_cycle", i), {31'd0, valid}, 32'd0);
        end

        // Start while busy is ignored; start during DONE is accepted.
        go(DIVU, 32'd100, 32'd7);
        repeat (9) begin @(posedge clk); #1; end
        op = DIVU; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_valid(11, lat);
        chk("busy_start_latency", lat, 33);
        chk("busy_start_result", res, 32'h0000000E);
        go(DIVU, 32'd1000, 32'd3);
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        chk("b2b_result_held", res, 32'h0000000E);
        wait_valid(1, lat);
        chk("b2b_latency", lat, 33);
        chk("b2b_result", res, 32'h0000014D);
        @(posedge clk); #1;

        // Flush mid-CALC returns to IDLE with no strobe and the old result kept.
        go(DIVU, 32'd100, 32'd7);
        repeat (14) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_valid", {31'd0, valid}, 32'd0);
        seen = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (valid) seen++;
        end
        chk("flush_no_valid", seen, 0);
        chk("flush_result_kept", res, 32'h0000014D);

        // Asynchronous reset mid-CALC clears outputs without waiting for a clock.
        go(DIVU, 32'd100, 32'd7);
        repeat (4) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_valid", {31'd0, valid}, 32'd0);
        chk("arst_result", res, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (valid) seen++;
        end
        chk("arst_no_valid", seen, 0);
        go(DIVU, 32'd100, 32'd7);
        wait_valid(1, lat);
        chk("post_reset_latency", lat, 33);
        chk("post_reset_result", res, 32'h0000000E);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
